// File: rtl/chacha_rounds.sv
// rtl/chacha_rounds.sv - iterative ChaCha core, one quarterround layer (4 parallel QRs) per clock.
// Define CHACHA_ROUNDS_FINAL_ADD_EN to add the initial state in FINAL (full block function).
module chacha_rounds (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [4:0]   rounds,
    input  logic [511:0] state_in,
    output logic         ready,
    output logic         valid,
    output logic [511:0] state_out
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

    fsm_t         fsm_q;
    logic [511:0] work_q;
    logic [4:0]   cnt_q;
    logic         odd_q;
    logic         ready_q;
    logic         valid_q;
    logic [511:0] out_q;
    logic [511:0] layer_d;
    logic [511:0] final_d;
`ifdef CHACHA_ROUNDS_FINAL_ADD_EN
    logic [511:0] init_q;
`endif

    function automatic logic [127:0] qr(input logic [31:0] a_in, input logic [31:0] b_in,
                                        input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {d, c, b, a};
    endfunction

    function automatic logic [511:0] columns(input logic [511:0] s);
        logic [511:0] o;
        logic [127:0] r;
        o = s;
        for (int j = 0; j < 4; j++) begin
            r = qr(s[32*j +: 32], s[128+32*j +: 32], s[256+32*j +: 32], s[384+32*j +: 32]);
            o[32*j +: 32]     = r[31:0];
            o[128+32*j +: 32] = r[63:32];
            o[256+32*j +: 32] = r[95:64];
            o[384+32*j +: 32] = r[127:96];
        end
        return o;
    endfunction

    // Rotating rows 1..3 left by 1..3 words turns the diagonals into columns.
    function automatic logic [511:0] shuffle(input logic [511:0] s, input logic inv);
        logic [127:0] r1, r2, r3;
        r1 = s[255:128];
        r2 = s[383:256];
        r3 = s[511:384];
        r2 = {r2[63:0], r2[127:64]};
        if (!inv) begin
            r1 = {r1[31:0], r1[127:32]};
            r3 = {r3[95:0], r3[127:96]};
        end else begin
            r1 = {r1[95:0], r1[127:96]};
            r3 = {r3[31:0], r3[127:32]};
        end
        return {r3, r2, r1, s[127:0]};
    endfunction

    always_comb begin
        layer_d = '0;
        if (odd_q) layer_d = shuffle(columns(shuffle(work_q, 1'b0)), 1'b1);
        else       layer_d = columns(work_q);
    end

    always_comb begin
        final_d = work_q;
`ifdef CHACHA_ROUNDS_FINAL_ADD_EN
        for (int i = 0; i < 16; i++) begin
            final_d[32*i +: 32] = work_q[32*i +: 32] + init_q[32*i +: 32];
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            odd_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            out_q   <= '0;
`ifdef CHACHA_ROUNDS_FINAL_ADD_EN
            init_q  <= '0;
`endif
        end else begin
            case (fsm_q)
                IDLE, DONE: begin
                    if (start) begin
                        work_q  <= state_in;
`ifdef CHACHA_ROUNDS_FINAL_ADD_EN
                        init_q  <= state_in;
`endif
                        cnt_q   <= rounds;
                        odd_q   <= 1'b0;
                        ready_q <= 1'b0;
                        valid_q <= 1'b0;
                        out_q   <= '0;
                        fsm_q   <= (rounds == 5'd0) ? FINAL : ROUND;
                    end
                end
                ROUND: begin
                    work_q <= layer_d;
                    odd_q  <= ~odd_q;
                    cnt_q  <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) fsm_q <= FINAL;
                end
                FINAL: begin
                    out_q   <= final_d;
                    valid_q <= 1'b1;
                    ready_q <= 1'b1;
                    fsm_q   <= DONE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign ready     = ready_q;
    assign valid     = valid_q;
    assign state_out = out_q;

endmodule

// File: tb/tb_chacha_rounds.sv
// tb/tb_chacha_rounds.sv - directed-vector bench for chacha_rounds.
module tb_chacha_rounds;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [4:0]   rounds;
    logic [511:0] state_in;
    logic         ready;
    logic         valid;
    logic [511:0] state_out;

    int n_vec = 0;
    int n_err = 0;

    chacha_rounds dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rounds    (rounds),
        .state_in  (state_in),
        .ready     (ready),
        .valid     (valid),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

`ifdef CHACHA_ROUNDS_FINAL_ADD_EN
    localparam logic ADD_EN = 1'b1;
`else
    localparam logic ADD_EN = 1'b0;
`endif

    localparam logic [511:0] RFC_IN = {
        32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001,
        32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
        32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
        32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accepts one job, optionally pokes a stray start 'poke' edges in, returns edges to valid.
    task automatic run(input logic [4:0] r, input logic [511:0] s, input int poke, output int lat);
        @(negedge clk);
        rounds   = r;
        state_in = s;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("accept_valid_low", 512'(valid), 512'(0));
        chk("accept_out_zero", state_out, '0);
        if (r != 5'd0) chk("busy_ready_low", 512'(ready), 512'(0));
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (valid) begin
                lat = n;
                break;
            end
            if (n == poke) begin
                chk("poke_ready_low", 512'(ready), 512'(0));
                start    = 1'b1;
                rounds   = 5'd0;
                state_in = '1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [511:0] s;
        logic [511:0] e;
        logic [31:0]  w0;

        reset    = 1'b1;
        start    = 1'b0;
        rounds   = 5'd0;
        state_in = '0;
        #1;
        chk("reset_ready", 512'(ready), 512'(1));
        chk("reset_valid", 512'(valid), 512'(0));
        chk("reset_out", state_out, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // RFC 8439 2.1.1 quarterround in column 0, other columns all-zero
        s = '0;
        s[31:0]    = 32'h11111111;
        s[159:128] = 32'h01020304;
        s[287:256] = 32'h9b8d6f43;
        s[415:384] = 32'h01234567;
        e = '0;
        e[31:0]    = 32'hea2a92f4;
        e[159:128] = 32'hcb1cf8ce;
        e[287:256] = 32'h4581472e;
        e[415:384] = 32'h5881c4bb;
        if (ADD_EN) begin
            e[31:0]    = e[31:0]    + 32'h11111111;
            e[159:128] = e[159:128] + 32'h01020304;
            e[287:256] = e[287:256] + 32'h9b8d6f43;
            e[415:384] = e[415:384] + 32'h01234567;
        end
        run(5'd1, s, 0, lat);
        chk("qr_latency", 512'(lat), 512'(2));
        chk("qr_out", state_out, e);
        chk("qr_ready", 512'(ready), 512'(1));

        // rounds=0: accepted from DONE, output in one edge
        s = '0;
        e = '0;
        for (int i = 0; i < 16; i++) begin
            s[32*i +: 32] = 32'(i);
            e[32*i +: 32] = ADD_EN ? 32'(2 * i) : 32'(i);
        end
        run(5'd0, s, 0, lat);
        chk("r0_latency", 512'(lat), 512'(1));
        chk("r0_out", state_out, e);

        // ChaCha20 block with a stray start 5 cycles in
        w0 = ADD_EN ? 32'he4e7f110 : 32'h837778ab;
        run(5'd20, RFC_IN, 5, lat);
        chk("rfc_latency", 512'(lat), 512'(21));
        chk("rfc_word0", 512'(state_out[31:0]), 512'(w0));
        e = state_out;
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold_out", state_out, e);
        chk("done_hold_valid", 512'(valid), 512'(1));
        chk("done_ready", 512'(ready), 512'(1));

        // Abort a run with reset at cycle 10
        @(negedge clk);
        rounds   = 5'd20;
        state_in = RFC_IN;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_valid", 512'(valid), 512'(0));
        chk("abort_ready", 512'(ready), 512'(1));
        chk("abort_out", state_out, '0);
        @(negedge clk);
        reset = 1'b0;
        run(5'd20, RFC_IN, 0, lat);
        chk("post_reset_latency", 512'(lat), 512'(21));
        chk("post_reset_word0", 512'(state_out[31:0]), 512'(w0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
